regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_if.sv | 30 +++
 rtl/regfile_wb_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between two requesters (ALU, load unit) and the register-file arbiter.
interface regfile_wb_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [4:0]  req0_reg;
  logic [31:0] req0_data;
  logic        req1_valid;
  logic        req1_ready;
  logic [4:0]  req1_reg;
  logic [31:0] req1_data;
  logic        wb;
  logic [4:0]  wb_reg;
  logic [31:0] busW;
  logic        grant_id;
  logic        busy;

  modport master (
    output req0_valid, req0_reg, req0_data,
    output req1_valid, req1_reg, req1_data,
    input  req0_ready, req1_ready,
    input  wb, wb_reg, busW, grant_id, busy
  );

  modport slave (
    input  req0_valid, req0_reg, req0_data,
    input  req1_valid, req1_reg, req1_data,
    output req0_ready, req1_ready,
    output wb, wb_reg, busW, grant_id, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-source register-file writeback arbiter with one holding slot per source.
// Optional macro RF_ZERO_GUARD_EN suppresses the write strobe for grants that target register 0.
module regfile_wb_arbiter (
  input  logic                 clock,
  input  logic                 reset_n,
  regfile_wb_arbiter_if.slave  bus
);
  logic        r_full0;
  logic        r_full1;
  logic [4:0]  r_reg0;
  logic [4:0]  r_reg1;
  logic [31:0] r_data0;
  logic [31:0] r_data1;
  logic        r_older;
  logic        r_tie;
  logic        r_rr;
  logic        r_wb;
  logic [4:0]  r_wb_reg;
  logic [31:0] r_busw;
  logic        r_grant_id;

  logic        w_cap0;
  logic        w_cap1;
  logic        w_any;
  logic        w_both;
  logic        w_sel;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_tie_gnt;
  logic        w_write;
  logic [4:0]  w_sel_reg;
  logic [31:0] w_sel_data;

  assign bus.req0_ready = ~r_full0 & reset_n;
  assign bus.req1_ready = ~r_full1 & reset_n;
  assign bus.wb         = r_wb;
  assign bus.wb_reg     = r_wb_reg;
  assign bus.busW       = r_busw;
  assign bus.grant_id   = r_grant_id;
  assign bus.busy       = r_full0 | r_full1 | r_wb;

  assign w_cap0    = bus.req0_valid & ~r_full0;
  assign w_cap1    = bus.req1_valid & ~r_full1;
  assign w_any     = r_full0 | r_full1;
  assign w_both    = r_full0 & r_full1;
  assign w_gnt0    = r_full0 & ~w_sel;
  assign w_gnt1    = r_full1 & w_sel;
  assign w_tie_gnt = w_both & r_tie;

  // Grant select: same-edge captures use the round-robin pointer, otherwise the older slot wins.
  always_comb begin
    w_sel = 1'b0;
    if (w_both) begin
      w_sel = r_tie ? r_rr : r_older;
    end else if (r_full1) begin
      w_sel = 1'b1;
    end else begin
      w_sel = 1'b0;
    end
  end

  always_comb begin
    w_sel_reg  = r_reg0;
    w_sel_data = r_data0;
    if (w_sel) begin
      w_sel_reg  = r_reg1;
      w_sel_data = r_data1;
    end else begin
      w_sel_reg  = r_reg0;
      w_sel_data = r_data0;
    end
  end

`ifdef RF_ZERO_GUARD_EN
  assign w_write = w_any & (w_sel_reg != 5'd0);
`else
  assign w_write = w_any;
`endif

  // Holding slots: a slot is captured only while empty, so capture and grant never coincide.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_full0 <= 1'b0;
      r_full1 <= 1'b0;
      r_reg0  <= 5'd0;
      r_reg1  <= 5'd0;
      r_data0 <= 32'd0;
      r_data1 <= 32'd0;
    end else begin
      if (w_cap0) begin
        r_full0 <= 1'b1;
        r_reg0  <= bus.req0_reg;
        r_data0 <= bus.req0_data;
      end else if (w_gnt0) begin
        r_full0 <= 1'b0;
      end else begin
        r_full0 <= r_full0;
      end
      if (w_cap1) begin
        r_full1 <= 1'b1;
        r_reg1  <= bus.req1_reg;
        r_data1 <= bus.req1_data;
      end else if (w_gnt1) begin
        r_full1 <= 1'b0;
      end else begin
        r_full1 <= r_full1;
      end
    end
  end

  // Age tracking: r_older names the slot holding the earlier capture, r_tie marks a same-edge pair.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_older <= 1'b0;
      r_tie   <= 1'b0;
      r_rr    <= 1'b0;
    end else begin
      if (w_cap0 && w_cap1) begin
        r_tie <= 1'b1;
      end else if (w_cap0) begin
        r_tie   <= 1'b0;
        r_older <= 1'b1;
      end else if (w_cap1) begin
        r_tie   <= 1'b0;
        r_older <= 1'b0;
      end else if (w_any) begin
        r_tie <= 1'b0;
      end else begin
        r_tie <= r_tie;
      end
      if (w_tie_gnt) begin
        r_rr <= ~r_rr;
      end else begin
        r_rr <= r_rr;
      end
    end
  end

  // Write port: address, data and source hold whenever no write is issued.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wb       <= 1'b0;
      r_wb_reg   <= 5'd0;
      r_busw     <= 32'd0;
      r_grant_id <= 1'b0;
    end else if (w_write) begin
      r_wb       <= 1'b1;
      r_wb_reg   <= w_sel_reg;
      r_busw     <= w_sel_data;
      r_grant_id <= w_sel;
    end else begin
      r_wb <= 1'b0;
    end
  end
endmodule
